// File: rtl/decode_pipe.sv
// decode_pipe: LEGv8 DECODE stage with IF/ID and ID/EX pipeline registers,
// register file (hardwired zero register), multi-format sign extension and
// internal load-use hazard detection.
// Optional feature macro: DECODE_BYPASS_EN (write-through bypass of the
// write-back port into the operands captured by ID/EX).
module decode_pipe #(
  parameter int N        = 64,
  parameter int NREG     = 32,
  parameter int ZERO_REG = 31
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [31:0]   instr_F,
  input  logic [N-1:0]  pc_F,
  input  logic          valid_F,
  input  logic          flush_D,
  input  logic          reg2loc_D,
  input  logic          regWrite_W,
  input  logic [4:0]    wa3_W,
  input  logic [N-1:0]  writeData3_W,
  output logic [31:0]   instr_D,
  output logic          stall_F,
  output logic          valid_E,
  output logic [31:0]   instr_E,
  output logic [N-1:0]  pc_E,
  output logic [N-1:0]  readData1_E,
  output logic [N-1:0]  readData2_E,
  output logic [N-1:0]  signImm_E
);

  localparam logic [5:0]  NREG_W   = 6'(NREG);
  localparam logic [4:0]  ZERO_IDX = 5'(ZERO_REG);
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [5:0]  OP_B     = 6'b000101;

  logic          valid_d;
  logic [N-1:0]  pc_d;
  logic [N-1:0]  rf [NREG];

  logic [4:0]    ra1;
  logic [4:0]    ra2;
  logic [4:0]    rd_e;
  logic          wr_en;
  logic          haz;
  logic [N-1:0]  rdata1;
  logic [N-1:0]  rdata2;
  logic [N-1:0]  sign_imm;

  assign ra1   = instr_D[9:5];
  assign ra2   = reg2loc_D ? instr_D[4:0] : instr_D[20:16];
  assign rd_e  = instr_E[4:0];
  assign wr_en = regWrite_W && (wa3_W != ZERO_IDX) && ({1'b0, wa3_W} < NREG_W);

  // Load-use hazard: the load in EX targets a register the instruction in D reads.
  assign haz = valid_d && valid_E && (instr_E[31:21] == OP_LDUR) &&
               (rd_e != ZERO_IDX) && ((rd_e == ra1) || (rd_e == ra2));

  // A flush kills the stalled instruction anyway, so it never holds fetch.
  assign stall_F = haz && !flush_D;

  // Register read ports; zero register and out-of-range indices read 0.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if ((ra1 != ZERO_IDX) && ({1'b0, ra1} < NREG_W)) rdata1 = rf[ra1];
    if ((ra2 != ZERO_IDX) && ({1'b0, ra2} < NREG_W)) rdata2 = rf[ra2];
`ifdef DECODE_BYPASS_EN
    if (wr_en && (wa3_W == ra1)) rdata1 = writeData3_W;
    if (wr_en && (wa3_W == ra2)) rdata2 = writeData3_W;
`endif
  end

  // Immediate extraction by instruction format, first matching opcode wins.
  always_comb begin
    sign_imm = '0;
    if ((instr_D[31:21] == OP_LDUR) || (instr_D[31:21] == OP_STUR))
      sign_imm = {{(N-9){instr_D[20]}}, instr_D[20:12]};
    else if (instr_D[31:24] == OP_CBZ)
      sign_imm = {{(N-19){instr_D[23]}}, instr_D[23:5]};
    else if (instr_D[31:26] == OP_B)
      sign_imm = {{(N-26){instr_D[25]}}, instr_D[25:0]};
  end

  // Register file write port; the zero register is never written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wr_en) begin
      rf[wa3_W] <= writeData3_W;
    end
  end

  // IF/ID register: flush clears, stall holds, otherwise take fetch output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_d <= 1'b0;
      instr_D <= '0;
      pc_d    <= '0;
    end else if (flush_D) begin
      valid_d <= 1'b0;
      instr_D <= '0;
      pc_d    <= '0;
    end else if (!stall_F) begin
      valid_d <= valid_F;
      instr_D <= instr_F;
      pc_d    <= pc_F;
    end
  end

  // ID/EX register: bubble on flush, hazard or empty D slot, else capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_E     <= 1'b0;
      instr_E     <= '0;
      pc_E        <= '0;
      readData1_E <= '0;
      readData2_E <= '0;
      signImm_E   <= '0;
    end else if (flush_D || haz || !valid_d) begin
      valid_E     <= 1'b0;
      instr_E     <= '0;
      pc_E        <= '0;
      readData1_E <= '0;
      readData2_E <= '0;
      signImm_E   <= '0;
    end else begin
      valid_E     <= 1'b1;
      instr_E     <= instr_D;
      pc_E        <= pc_d;
      readData1_E <= rdata1;
      readData2_E <= rdata2;
      signImm_E   <= sign_imm;
    end
  end

endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: scoreboard bench for decode_pipe. A transaction-level model
// predicts the ID/EX slot for every clock and queues it; a monitor pops one
// entry per clock edge and compares. Honours DECODE_BYPASS_EN like the DUT.
module tb_decode_pipe;

  localparam int N    = 64;
  localparam int NREG = 32;
  localparam int ZR   = 31;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [31:0]   instr_F;
  logic [N-1:0]  pc_F;
  logic          valid_F;
  logic          flush_D;
  logic          reg2loc_D;
  logic          regWrite_W;
  logic [4:0]    wa3_W;
  logic [N-1:0]  writeData3_W;
  logic [31:0]   instr_D;
  logic          stall_F;
  logic          valid_E;
  logic [31:0]   instr_E;
  logic [N-1:0]  pc_E;
  logic [N-1:0]  readData1_E;
  logic [N-1:0]  readData2_E;
  logic [N-1:0]  signImm_E;

  decode_pipe #(.N(N), .NREG(NREG), .ZERO_REG(ZR)) dut (
    .clk(clk), .reset_n(reset_n), .instr_F(instr_F), .pc_F(pc_F),
    .valid_F(valid_F), .flush_D(flush_D), .reg2loc_D(reg2loc_D),
    .regWrite_W(regWrite_W), .wa3_W(wa3_W), .writeData3_W(writeData3_W),
    .instr_D(instr_D), .stall_F(stall_F), .valid_E(valid_E),
    .instr_E(instr_E), .pc_E(pc_E), .readData1_E(readData1_E),
    .readData2_E(readData2_E), .signImm_E(signImm_E)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic [63:0] imm;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;

  // Reference model state: architectural registers plus the D and E slots.
  logic [63:0] m_rf [NREG];
  logic        m_d_valid;
  logic [31:0] m_d_instr;
  logic [63:0] m_d_pc;
  logic        m_e_valid;
  logic [31:0] m_e_instr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] enc_ldur(int rt, int rn, int imm9);
    return {11'b11111000010, 9'(imm9), 2'b00, 5'(rn), 5'(rt)};
  endfunction
  function automatic logic [31:0] enc_stur(int rt, int rn, int imm9);
    return {11'b11111000000, 9'(imm9), 2'b00, 5'(rn), 5'(rt)};
  endfunction
  function automatic logic [31:0] enc_cbz(int rt, int imm19);
    return {8'b10110100, 19'(imm19), 5'(rt)};
  endfunction
  function automatic logic [31:0] enc_b(int imm26);
    return {6'b000101, 26'(imm26)};
  endfunction
  function automatic logic [31:0] enc_add(int rd, int rn, int rm);
    return {11'b10001011000, 5'(rm), 6'b000000, 5'(rn), 5'(rd)};
  endfunction

  // Two's-complement value of a w-bit field, widened to 64 bits.
  function automatic logic [63:0] sext_field(longint v, int w);
    longint r;
    r = v;
    if (r >= (64'sd1 <<< (w - 1))) r = r - (64'sd1 <<< w);
    return 64'(r);
  endfunction

  function automatic bit is_ldur(logic [31:0] ins);
    return ins[31:21] == 11'b11111000010;
  endfunction

  function automatic logic [63:0] model_imm(logic [31:0] ins);
    if (is_ldur(ins) || ins[31:21] == 11'b11111000000) return sext_field(longint'(ins[20:12]), 9);
    if (ins[31:24] == 8'b10110100) return sext_field(longint'(ins[23:5]), 19);
    if (ins[31:26] == 6'b000101) return sext_field(longint'(ins[25:0]), 26);
    return 64'd0;
  endfunction

  function automatic bit legal_write();
    return regWrite_W && (int'(wa3_W) != ZR) && (int'(wa3_W) < NREG);
  endfunction

  function automatic logic [63:0] model_read(logic [4:0] idx);
    if (int'(idx) == ZR || int'(idx) >= NREG) return 64'd0;
`ifdef DECODE_BYPASS_EN
    if (legal_write() && wa3_W == idx) return writeData3_W;
`endif
    return m_rf[idx];
  endfunction

  function automatic logic [4:0] model_ra2();
    return reg2loc_D ? m_d_instr[4:0] : m_d_instr[20:16];
  endfunction

  function automatic bit model_haz();
    logic [4:0] rd;
    rd = m_e_instr[4:0];
    return m_d_valid && m_e_valid && is_ldur(m_e_instr) && (int'(rd) != ZR) &&
           (rd == m_d_instr[9:5] || rd == model_ra2());
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_rf[i] = 64'd0;
    m_d_valid = 1'b0; m_d_instr = '0; m_d_pc = '0;
    m_e_valid = 1'b0; m_e_instr = '0;
  endtask

  // Predict the effect of the coming clock edge and queue the expected E slot.
  task automatic model_advance();
    exp_t e;
    bit   h;
    h = model_haz();
    e = '{valid: 1'b0, instr: '0, pc: '0, rd1: '0, rd2: '0, imm: '0};
    if (!flush_D && !h && m_d_valid) begin
      e.valid = 1'b1;
      e.instr = m_d_instr;
      e.pc    = m_d_pc;
      e.rd1   = model_read(m_d_instr[9:5]);
      e.rd2   = model_read(model_ra2());
      e.imm   = model_imm(m_d_instr);
    end
    exp_q.push_back(e);
    m_e_valid = e.valid;
    m_e_instr = e.instr;
    if (flush_D) begin
      m_d_valid = 1'b0; m_d_instr = '0; m_d_pc = '0;
    end else if (!h) begin
      m_d_valid = valid_F; m_d_instr = instr_F; m_d_pc = pc_F;
    end
    if (legal_write()) m_rf[wa3_W] = writeData3_W;
  endtask

  task automatic check_output();
    check("stall_F", 64'(stall_F), 64'(model_haz() && !flush_D));
    check("instr_D", 64'(instr_D), 64'(m_d_instr));
  endtask

  // One clock: drive inputs after the falling edge, check D-side, predict.
  task automatic apply_stimulus(input logic [31:0] ins, input logic vf, input logic fl,
                                input logic r2l, input logic we, input logic [4:0] wa,
                                input logic [63:0] wd);
    instr_F = ins; pc_F = {$urandom, $urandom}; valid_F = vf; flush_D = fl;
    reg2loc_D = r2l; regWrite_W = we; wa3_W = wa; writeData3_W = wd;
    #1;
    check_output();
    if (reset_n) model_advance();
    @(negedge clk);
  endtask

  task automatic idle();
    apply_stimulus(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid_E"}, 64'(valid_E), 64'd0);
    check({tag, "_instr_E"}, 64'(instr_E), 64'd0);
    check({tag, "_pc_E"}, pc_E, 64'd0);
    check({tag, "_rd1"}, readData1_E, 64'd0);
    check({tag, "_rd2"}, readData2_E, 64'd0);
    check({tag, "_imm"}, signImm_E, 64'd0);
    check({tag, "_instr_D"}, 64'(instr_D), 64'd0);
    check({tag, "_stall"}, 64'(stall_F), 64'd0);
  endtask

  // Assert reset while a load-use stall is visible, then release it.
  task automatic reset_mid_stall();
    instr_F = '0; valid_F = 1'b0; flush_D = 1'b0; reg2loc_D = 1'b0; regWrite_W = 1'b0;
    #1;
    check("pre_reset_stall", 64'(stall_F), 64'd1);
    reset_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    model_reset();
    @(negedge clk);
    idle();
    reset_n = 1'b1;
  endtask

  function automatic int pick_reg();
    return ($urandom_range(0, 7) == 0) ? ZR : int'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] rand_instr();
    case ($urandom_range(0, 5))
      0: return enc_ldur(pick_reg(), pick_reg(), int'($urandom_range(0, 511)));
      1: return enc_stur(pick_reg(), pick_reg(), int'($urandom_range(0, 511)));
      2: return enc_cbz(pick_reg(), int'($urandom & 32'h7FFFF));
      3: return enc_b(int'($urandom & 32'h3FFFFFF));
      4: return enc_add(pick_reg(), pick_reg(), pick_reg());
      default: return $urandom;
    endcase
  endfunction

  // Monitor: one expected E-slot entry per clock edge out of reset.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (reset_n) begin
        #1;
        if (exp_q.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("valid_E", 64'(valid_E), 64'(e.valid));
          check("instr_E", 64'(instr_E), 64'(e.instr));
          check("pc_E", pc_E, e.pc);
          check("readData1_E", readData1_E, e.rd1);
          check("readData2_E", readData2_E, e.rd2);
          check("signImm_E", signImm_E, e.imm);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_n = 1'b0;
    instr_F = '0; pc_F = '0; valid_F = 1'b0; flush_D = 1'b0; reg2loc_D = 1'b0;
    regWrite_W = 1'b0; wa3_W = '0; writeData3_W = '0;
    model_reset();
    @(negedge clk);
    check_all_zero("reset");
    idle();
    reset_n = 1'b1;

    // Write X1, X2 then ADD X3,X1,X2.
    apply_stimulus(32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 64'h5);
    apply_stimulus(32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 64'h7);
    apply_stimulus(enc_add(3, 1, 2), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
    // Attempt a write to XZR, then read XZR as ra1.
    apply_stimulus(32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd31, 64'hFFFF);
    apply_stimulus(enc_add(0, 31, 1), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
    // Sign-extension formats at their boundaries.
    apply_stimulus(enc_ldur(8, 9, 9'h1FF), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
    apply_stimulus(enc_cbz(10, 19'h00010), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
    apply_stimulus(enc_b(26'h2000000), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
    idle(); idle();
    // Load-use: LDUR X4 then ADD X5,X4,X6.
    apply_stimulus(enc_ldur(4, 1, 0), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
    apply_stimulus(enc_add(5, 4, 6), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
    idle(); idle(); idle();
    // Flush together with a load-use hazard.
    apply_stimulus(enc_ldur(4, 1, 0), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
    apply_stimulus(enc_add(5, 4, 6), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
    apply_stimulus(enc_add(9, 1, 2), 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 64'd0);
    idle(); idle();
    // Write X7 on the same edge that ADD captures X7.
    apply_stimulus(enc_add(11, 7, 0), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
    apply_stimulus(32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 64'hAB);
    apply_stimulus(enc_add(12, 7, 7), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
    idle(); idle();
    // Reset in the middle of a stall.
    apply_stimulus(enc_ldur(4, 1, 0), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
    apply_stimulus(enc_add(5, 4, 6), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
    reset_mid_stall();
    idle();

    // Randomized traffic over a small register set so hazards are frequent.
    for (int i = 0; i < 400; i++) begin
      apply_stimulus(rand_instr(), 1'($urandom_range(0, 9) != 0),
                     1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 5'(pick_reg()), {$urandom, $urandom});
    end
    for (int i = 0; i < 4; i++) idle();
    #2;
    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_pipe.md
Name: decode_pipe

Overview:
- Parametrised next-generation DECODE stage for the pipelined LEGv8 core.
- Owns the IF/ID and ID/EX pipeline registers, a register file with a hardwired zero register, and multi-format sign extension.
- Detects load-use hazards internally and stalls fetch.
- Accepts a branch flush from EXECUTE.
- Sits between fetch and execute. The control unit decodes instr_D and returns reg2loc_D.

Parameters:
- N, 64, datapath and register width in bits.
- NREG, 32, number of architectural registers; register index width is 5 bits, and NREG must be ≤32.
- ZERO_REG, 31, index that always reads as 0 and ignores writes (XZR).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- instr_F  in  32  instruction from fetch.
- pc_F  in  N  PC of instr_F.
- valid_F  in  1  instr_F is a real instruction.
- flush_D  in  1  branch taken in EX; kill instructions in D and F.
- reg2loc_D  in  1  selects the ra2 source: 0 = instr_D[20:16], 1 = instr_D[4:0].
- regWrite_W  in  1  write-back enable.
- wa3_W  in  5  write-back register index.
- writeData3_W  in  N  write-back data.
- instr_D  out  32  IF/ID instruction, sent to control.
- stall_F  out  1  hold PC and fetch output this cycle.
- valid_E  out  1  ID/EX slot holds a real instruction.
- instr_E  out  32  ID/EX instruction.
- pc_E  out  N  ID/EX PC.
- readData1_E  out  N  ID/EX operand 1.
- readData2_E  out  N  ID/EX operand 2.
- signImm_E  out  N  ID/EX sign-extended immediate.

Behaviour:
- Reset: while reset_n=0, all pipeline registers and all regfile entries are 0 (asynchronous), so every output is 0. On release, the first rising edge performs a normal update.
- Register read addresses:
  - ra1 = instr_D[9:5].
  - ra2 = mux(reg2loc_D).
  - Any read of ZERO_REG returns 0.
  - An index ≥ NREG reads 0.
- Register write: on the rising edge when regWrite_W=1 and wa3_W != ZERO_REG and wa3_W < NREG.
- Sign extension is decided from instr_D, first match wins:
  - LDUR (instr[31:21]=11111000010) or STUR (=11111000000): sext(instr[20:12]).
  - CBZ (instr[31:24]=10110100): sext(instr[23:5]).
  - B (instr[31:26]=000101): sext(instr[25:0]).
  - Anything else: 0.
  - All results are extended to N bits.
- Load-use hazard: haz = valid_D & valid_E & (instr_E is LDUR) & (rdE != ZERO_REG) & (rdE==ra1 | rdE==ra2), where rdE = instr_E[4:0].
  - ra2 is always compared, regardless of opcode.
- stall_F = haz & ~flush_D. This is combinational from registered state plus flush_D.
- IF/ID update, in priority order:
  - flush_D: valid_D←0, instr_D←0, pc_D←0.
  - stall_F: hold.
  - otherwise: load instr_F, pc_F, valid_F.
- ID/EX update:
  - If flush_D | haz | ~valid_D: insert a bubble. valid_E, instr_E, pc_E, operands and signImm_E all ←0.
  - Otherwise: capture pc_D, instr_D, both read data and signImm.
- Latency: an instruction captured into IF/ID at edge k appears on the *_E outputs after edge k+1 when there is no stall. Each stall adds one cycle.
- Simultaneous flush and hazard: flush wins, and stall_F=0.
- Reset asserted mid-stall clears everything. No residual stall after release.

Optional Feature:
- Macro: DECODE_BYPASS_EN.
- Defined: write-through bypass. If the same edge writes register r (a legal write) and the ID/EX capture reads r, the captured operand is writeData3_W.
- Undefined: the captured operand is the pre-write register content. The write still lands at that edge, and the software/hazard unit must cover the gap.

Test Plan:
- Reset, then write X1=0x5, X2=0x7 via W port; ADD X3,X1,X2 flows in → next-cycle readData1_E=5, readData2_E=7, valid_E=1.
- Write X31=0xFFFF, then read X31 as ra1 → readData1_E=0.
- Sign extension:
  - LDUR with imm9=0x1FF → signImm_E=all-ones (−1).
  - CBZ with imm19=0x00010 → signImm_E=0x10.
  - B with imm26=0x2000000 → signImm_E=0xFFFF_FFFF_FE00_0000.
- LDUR X4 in EX, ADD X5,X4,X6 in D → stall_F=1 for exactly one cycle, a bubble (valid_E=0) is inserted, then ADD issues with instr_E intact.
- flush_D asserted together with the load-use hazard → stall_F=0; the next cycle has valid_D=0 and valid_E=0.
- Bypass: regWrite_W X7=0xAB on the same edge that ADD reads X7:
  - With DECODE_BYPASS_EN, readData1_E=0xAB.
  - Without it, readData1_E=old value (0 after reset).
